// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - lamp-bus phase decoder with order and dwell-time checking
// Decodes (M1,M2,MT,S) into phase 1..6 and flags illegal, out-of-order and mistimed phases.
module traffic_light_monitor #(
  parameter int TMG = 7,
  parameter int TY  = 2,
  parameter int TTG = 5,
  parameter int TSG = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  light_M1,
  input  logic [2:0]  light_M2,
  input  logic [2:0]  light_MT,
  input  logic [2:0]  light_S,
  output logic [2:0]  phase,
  output logic        in_sync,
  output logic        err_illegal,
  output logic        err_order,
  output logic        err_timing,
  output logic        err_sticky,
  output logic        cycle_done,
  output logic [15:0] cycle_count
);

  localparam logic [0:0] SYNC  = 1'b0;
  localparam logic [0:0] TRACK = 1'b1;

  logic [0:0] state;
  logic [2:0] dec;
  logic [2:0] prev_dec;
  logic [2:0] nxt;
  logic [3:0] dwell;
  logic [3:0] exp_dwell;

  always_comb begin
    dec = 3'd0;
    case ({light_M1, light_M2, light_MT, light_S})
      12'b001_001_100_100: dec = 3'd1;
      12'b001_010_100_100: dec = 3'd2;
      12'b001_100_001_100: dec = 3'd3;
      12'b010_100_010_100: dec = 3'd4;
      12'b100_100_100_001: dec = 3'd5;
      12'b100_100_100_010: dec = 3'd6;
      default:             dec = 3'd0;
    endcase
  end

  always_comb begin
    exp_dwell = 4'd0;
    case (phase)
      3'd1:                   exp_dwell = 4'(TMG + 1);
      3'd2, 3'd4, 3'd6:       exp_dwell = 4'(TY + 1);
      3'd3:                   exp_dwell = 4'(TTG + 1);
      3'd5:                   exp_dwell = 4'(TSG + 1);
      default:                exp_dwell = 4'd0;
    endcase
  end

  assign nxt = (phase == 3'd6) ? 3'd1 : phase + 3'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SYNC;
      phase       <= 3'd0;
      in_sync     <= 1'b0;
      dwell       <= 4'd0;
      prev_dec    <= 3'd0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      err_timing  <= 1'b0;
      err_sticky  <= 1'b0;
      cycle_done  <= 1'b0;
      cycle_count <= 16'd0;
    end else begin
      prev_dec    <= dec;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      err_timing  <= 1'b0;
      cycle_done  <= 1'b0;
      if (state == SYNC) begin
        if (dec == 3'd0) begin
          err_illegal <= 1'b1;
          err_sticky  <= 1'b1;
        end else if (dec == 3'd1 && prev_dec != 3'd1) begin
          // Only a fresh edge into S1 may start tracking; a held S1 is ignored.
          state   <= TRACK;
          phase   <= 3'd1;
          in_sync <= 1'b1;
          dwell   <= 4'd1;
        end
      end else begin
        if (dec == phase && dwell != exp_dwell) begin
          if (dwell != 4'd15) dwell <= dwell + 4'd1;
        end else if (dec == nxt && dwell == exp_dwell) begin
          phase <= nxt;
          dwell <= 4'd1;
          if (nxt == 3'd1) begin
            cycle_done  <= 1'b1;
            cycle_count <= cycle_count + 16'd1;
          end
        end else begin
          // Every remaining case is a violation that drops tracking.
          state      <= SYNC;
          phase      <= 3'd0;
          in_sync    <= 1'b0;
          dwell      <= 4'd0;
          err_sticky <= 1'b1;
          if (dec == 3'd0)                       err_illegal <= 1'b1;
          else if (dec != phase && dec != nxt)   err_order   <= 1'b1;
          else                                   err_timing  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - randomized and directed checks against a phase-run model
module tb_traffic_light_monitor;

  localparam int TMG = 7;
  localparam int TY  = 2;
  localparam int TTG = 5;
  localparam int TSG = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  light_M1, light_M2, light_MT, light_S;
  logic [2:0]  phase;
  logic        in_sync, err_illegal, err_order, err_timing, err_sticky, cycle_done;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] pat [1:6];
  int          dur [1:6];

  int m_sync, m_phase, m_run, m_prev, m_count, m_sticky;
  int m_ill, m_ord, m_tim, m_done;

  traffic_light_monitor #(.TMG(TMG), .TY(TY), .TTG(TTG), .TSG(TSG)) dut (
    .clk(clk), .reset(reset),
    .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
    .phase(phase), .in_sync(in_sync),
    .err_illegal(err_illegal), .err_order(err_order), .err_timing(err_timing),
    .err_sticky(err_sticky), .cycle_done(cycle_done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mdec(input logic [11:0] p);
    for (int i = 1; i <= 6; i++) if (pat[i] == p) return i;
    return 0;
  endfunction

  task automatic lose_sync();
    m_sync  = 0;
    m_phase = 0;
    m_run   = 0;
  endtask

  task automatic model(input int r, input logic [11:0] p);
    int d, nx;
    d = mdec(p);
    m_ill = 0; m_ord = 0; m_tim = 0; m_done = 0;
    if (r != 0) begin
      lose_sync();
      m_prev = 0; m_count = 0; m_sticky = 0;
      return;
    end
    if (m_sync == 0) begin
      if (d == 0) m_ill = 1;
      else if (d == 1 && m_prev != 1) begin
        m_sync = 1; m_phase = 1; m_run = 1;
      end
    end else begin
      nx = m_phase % 6 + 1;
      if (d == m_phase) begin
        if (m_run == dur[m_phase]) begin m_tim = 1; lose_sync(); end
        else m_run++;
      end else if (d == nx) begin
        if (m_run != dur[m_phase]) begin m_tim = 1; lose_sync(); end
        else begin
          m_phase = nx; m_run = 1;
          if (nx == 1) begin m_done = 1; m_count = (m_count + 1) % 65536; end
        end
      end else if (d == 0) begin m_ill = 1; lose_sync(); end
      else begin m_ord = 1; lose_sync(); end
    end
    if (m_ill + m_ord + m_tim > 0) m_sticky = 1;
    m_prev = d;
  endtask

  task automatic step(input logic [11:0] p, input logic r);
    reset = r;
    {light_M1, light_M2, light_MT, light_S} = p;
    @(posedge clk);
    #1;
    model(int'(r), p);
    check("phase",       32'(phase),       32'(m_phase));
    check("in_sync",     32'(in_sync),     32'(m_sync));
    check("err_illegal", 32'(err_illegal), 32'(m_ill));
    check("err_order",   32'(err_order),   32'(m_ord));
    check("err_timing",  32'(err_timing),  32'(m_tim));
    check("err_sticky",  32'(err_sticky),  32'(m_sticky));
    check("cycle_done",  32'(cycle_done),  32'(m_done));
    check("cycle_count", 32'(cycle_count), 32'(m_count));
  endtask

  task automatic hold(input int ph, input int n);
    for (int i = 0; i < n; i++) step(pat[ph], 1'b0);
  endtask

  task automatic full_cycle();
    for (int ph = 1; ph <= 6; ph++) hold(ph, dur[ph]);
  endtask

  initial begin
    int gp, n, r;
    pat[1] = 12'b001_001_100_100;  pat[2] = 12'b001_010_100_100;
    pat[3] = 12'b001_100_001_100;  pat[4] = 12'b010_100_010_100;
    pat[5] = 12'b100_100_100_001;  pat[6] = 12'b100_100_100_010;
    dur[1] = TMG + 1; dur[2] = TY + 1; dur[3] = TTG + 1;
    dur[4] = TY + 1;  dur[5] = TSG + 1; dur[6] = TY + 1;
    m_sync = 0; m_phase = 0; m_run = 0; m_prev = 0; m_count = 0; m_sticky = 0;

    // Reset state, then three clean controller cycles.
    step(12'hFFF, 1'b1);
    step(12'hFFF, 1'b1);
    for (int c = 0; c < 3; c++) full_cycle();
    step(pat[1], 1'b0);
    check("t1_count", 32'(cycle_count), 32'd3);
    check("t1_sticky", 32'(err_sticky), 32'd0);

    // Illegal blank mid-S3, then resync on the following S1 entry.
    hold(1, dur[1] - 1); hold(2, dur[2]); hold(3, 2);
    step(12'h000, 1'b0);
    check("t2_illegal", 32'(err_illegal), 32'd1);
    hold(3, 3); hold(4, 3); hold(5, 4); hold(6, 3);
    full_cycle();
    check("t2_sticky", 32'(err_sticky), 32'd1);

    // Overrun on a held S1, then a stuck S1 must not resync.
    step(12'hFFF, 1'b1);
    hold(1, 9);
    check("t3_timing", 32'(err_timing), 32'd1);
    hold(1, 5);
    check("t3_phase", 32'(phase), 32'd0);

    // Short S2, then S1 straight into S3.
    step(12'hFFF, 1'b1);
    hold(1, 8); hold(2, 2); hold(3, 1);
    check("t4_timing", 32'(err_timing), 32'd1);
    hold(6, 1);
    hold(1, 8); hold(3, 1);
    check("t5_order", 32'(err_order), 32'd1);

    // Reset mid-S4 with history, then clean resync.
    step(12'hFFF, 1'b1);
    step(12'h000, 1'b0);
    for (int c = 0; c < 5; c++) full_cycle();
    hold(1, 8); hold(2, 3); hold(3, 6); hold(4, 1);
    check("t6_count_pre", 32'(cycle_count), 32'd5);
    step(pat[4], 1'b1);
    check("t6_count", 32'(cycle_count), 32'd0);
    full_cycle();
    step(pat[1], 1'b0);
    check("t6_count_post", 32'(cycle_count), 32'd1);

    // Randomized traffic: mostly lawful phases with perturbations.
    gp = 1;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        gp = gp % 6 + 1;
        n = dur[gp];
        if ($urandom_range(0, 99) < 15) n = n + $urandom_range(0, 2) - 1;
        hold(gp, n);
      end else if (r < 80) begin
        step(12'($urandom_range(0, 4095)), 1'b0);
      end else if (r < 90) begin
        gp = $urandom_range(1, 6);
        hold(gp, $urandom_range(1, 9));
      end else if (r < 94) begin
        step(12'($urandom_range(0, 4095)), 1'b1);
        gp = 6;
      end else begin
        gp = 1;
        hold(gp, $urandom_range(1, 10));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
